debug_unit: RTL and testbench

DEBUG_UNIT -- requirements
Module: debug_unit

---
 rtl/debug_unit.sv | 99 +++++++++
 tb/tb_debug_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
// Debug reporter: runs the cpu until HALT, then streams a 6-byte snapshot
// (pc, acc, cycle count, little-endian) through a byte transmitter.
module debug_unit #(
  parameter int DATA_LENGTH = 16,
  parameter int BYTE_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   halt,
  input  logic [DATA_LENGTH-1:0] pc,
  input  logic [DATA_LENGTH-1:0] acc,
  input  logic                   tx_done,
  output logic                   cpu_enable,
  output logic                   tx_start,
  output logic [BYTE_LENGTH-1:0] tx_data,
  output logic                   done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    SEND    = 3'd2,
    WAIT_TX = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'd5;

  state_t                 state, next_state;
  logic [DATA_LENGTH-1:0] cycle_cnt;
  logic [DATA_LENGTH-1:0] snap_pc, snap_acc, snap_cnt;
  logic [2:0]             idx;

  function automatic logic [DATA_LENGTH-1:0] sat_inc(input logic [DATA_LENGTH-1:0] v);
    return (&v) ? v : v + DATA_LENGTH'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (halt) next_state = SEND;
      SEND:    next_state = WAIT_TX;
      WAIT_TX: if (tx_done) next_state = (idx == LAST_IDX) ? DONE : SEND;
      DONE:    next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  // The count captured on the halt edge includes that edge's own increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
      snap_pc   <= '0;
      snap_acc  <= '0;
      snap_cnt  <= '0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: if (start) cycle_cnt <= '0;
        RUN: begin
          cycle_cnt <= sat_inc(cycle_cnt);
          if (halt) begin
            snap_pc  <= pc;
            snap_acc <= acc;
            snap_cnt <= sat_inc(cycle_cnt);
            idx      <= '0;
          end
        end
        WAIT_TX: if (tx_done && idx != LAST_IDX) idx <= idx + 3'd1;
        default: ;
      endcase
    end
  end

  // tx_data only changes when idx or the snapshot changes, i.e. on entry to SEND.
  always_comb begin
    cpu_enable = (state == RUN);
    tx_start   = (state == SEND);
    done       = (state == DONE);
    tx_data    = '0;
    case (idx)
      3'd0:    tx_data = snap_pc[BYTE_LENGTH-1:0];
      3'd1:    tx_data = snap_pc[2*BYTE_LENGTH-1:BYTE_LENGTH];
      3'd2:    tx_data = snap_acc[BYTE_LENGTH-1:0];
      3'd3:    tx_data = snap_acc[2*BYTE_LENGTH-1:BYTE_LENGTH];
      3'd4:    tx_data = snap_cnt[BYTE_LENGTH-1:0];
      3'd5:    tx_data = snap_cnt[2*BYTE_LENGTH-1:BYTE_LENGTH];
      default: tx_data = '0;
    endcase
  end

endmodule

// File: tb/tb_debug_unit.sv
// Randomized bench for debug_unit: expected report bytes are queued by the
// driver and checked by an independent monitor whenever tx_start is seen.
module tb_debug_unit;

  logic        clk = 1'b0;
  logic        reset, start, halt, tx_done;
  logic [15:0] pc, acc;
  logic        cpu_enable, tx_start, done;
  logic [7:0]  tx_data;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  last_tx;
  logic [7:0]  exp_byte;
  bit          have_last = 1'b0;

  debug_unit #(.DATA_LENGTH(16), .BYTE_LENGTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .pc(pc), .acc(acc), .tx_done(tx_done),
    .cpu_enable(cpu_enable), .tx_start(tx_start), .tx_data(tx_data), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every tx_start must carry the next queued byte; between
  // transmissions tx_data must hold the last transmitted byte.
  always @(negedge clk) begin
    if (reset) have_last = 1'b0;
    else if (tx_start) begin
      if (exp_q.size() == 0) chk("tx_start_unexpected", 32'd1, 32'd0);
      else begin
        exp_byte = exp_q.pop_front();
        chk("tx_byte", tx_data, exp_byte);
      end
      last_tx   = tx_data;
      have_last = 1'b1;
    end else if (have_last) chk("tx_data_hold", tx_data, last_tx);
  end

  task automatic apply_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_cpu_enable", cpu_enable, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_done", done, 0);
    exp_q.delete();
    start = 1'b0; halt = 1'b0; tx_done = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  // One report: run for run_cycles RUN edges (halt sampled on the last),
  // answer each byte after dly WAIT_TX cycles; optionally abort by reset.
  task automatic report(input int run_cycles, input logic [15:0] p, input logic [15:0] a,
                        input int dly, input bit halt_at_start, input int abort_after);
    int          cnt_exp, en_cnt;
    logic [15:0] w;
    cnt_exp = (run_cycles > 65535) ? 65535 : run_cycles;
    @(negedge clk);
    chk("idle_cpu_enable", cpu_enable, 0);
    chk("idle_done", done, 0);
    start = 1'b1;
    halt  = halt_at_start;
    @(negedge clk);
    start  = 1'b0;
    en_cnt = 0;
    for (int i = 1; i < run_cycles; i++) begin
      en_cnt += int'(cpu_enable);
      halt = 1'b0;
      pc   = 16'($urandom);
      acc  = 16'($urandom);
      @(negedge clk);
    end
    en_cnt += int'(cpu_enable);
    halt = 1'b1; pc = p; acc = a;
    for (int k = 0; k < 6; k++) begin
      w = (k < 2) ? p : (k < 4) ? a : 16'(cnt_exp);
      exp_q.push_back(8'((w >> (8 * (k % 2))) & 16'hFF));
    end
    @(negedge clk);
    halt = halt_at_start;
    chk("cpu_enable_cycles", en_cnt, run_cycles);
    chk("cpu_frozen", cpu_enable, 0);
    for (int b = 0; b < 6; b++) begin
      chk("tx_start_pulse", tx_start, 1);
      tx_done = 1'($urandom_range(0, 1));
      start   = 1'($urandom_range(0, 1));
      pc = 16'($urandom); acc = 16'($urandom);
      @(negedge clk);
      tx_done = 1'b0; start = 1'b0;
      chk("tx_start_one_cycle", tx_start, 0);
      for (int d = 1; d < dly; d++) begin
        if (b == abort_after && d == 1) begin
          apply_reset();
          for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("abort_no_tx_start", tx_start, 0);
            chk("abort_cpu_enable", cpu_enable, 0);
          end
          return;
        end
        chk("wait_no_tx_start", tx_start, 0);
        chk("wait_done_low", done, 0);
        pc    = 16'($urandom); acc = 16'($urandom);
        halt  = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      start = 1'b0; tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
    chk("done_set", done, 1);
    chk("done_cpu_enable", cpu_enable, 0);
    for (int j = 0; j < 4; j++) begin
      start   = 1'($urandom_range(0, 1));
      tx_done = 1'($urandom_range(0, 1));
      halt    = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("done_terminal", done, 1);
      chk("done_no_tx_start", tx_start, 0);
    end
    start = 1'b0; tx_done = 1'b0; halt = 1'b0;
    chk("report_bytes_consumed", exp_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; start = 1'b0; halt = 1'b0; tx_done = 1'b0; pc = '0; acc = '0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("init_cpu_enable", cpu_enable, 0);
    chk("init_tx_start", tx_start, 0);
    chk("init_tx_data", tx_data, 0);
    chk("init_done", done, 0);
    #2 reset = 1'b0;

    report(10, 16'h0007, 16'h1234, 3, 1'b0, -1);
    apply_reset();
    report(6, 16'hBEEF, 16'hCAFE, 50, 1'b0, -1);
    apply_reset();
    report(1, 16'h00A5, 16'h5A00, 4, 1'b1, -1);
    apply_reset();
    report(65537, 16'h1357, 16'h2468, 2, 1'b0, -1);
    apply_reset();
    report(7, 16'h4321, 16'h8765, 6, 1'b0, 2);
    report(12, 16'hF00D, 16'h0BAD, 3, 1'b0, -1);
    for (int r = 0; r < 4; r++) begin
      apply_reset();
      report(int'($urandom_range(1, 40)), 16'($urandom), 16'($urandom),
             int'($urandom_range(1, 20)), 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
